// File: rtl/bf_loop_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf_loop_sequencer                                            |
// | Description : BF program sequencer: fetches commands, resolves '[' / ']'  |
// |               and dispatches non-branch commands over valid/ready.         |
// |               Define BF_LOOP_STACK_EN for a loop-return stack.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bf_loop_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16,
  parameter int NEST_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              prog_rd,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [2:0]        prog_cmd,
  input  logic [7:0]        cell_value,
  output logic              exec_valid,
  output logic [2:0]        exec_command,
  input  logic              exec_ready,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam logic [2:0]        c_cmd_open  = 3'b010;
  localparam logic [2:0]        c_cmd_close = 3'b011;
  localparam logic [2:0]        c_cmd_end   = 3'b111;
  localparam logic [ADDR_W-1:0] c_pc_max    = '1;
  localparam logic [NEST_W-1:0] c_nest_max  = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_SCAN_FETCH, S_SCAN_WAIT, S_HALT, S_ERROR
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_cmd;
  logic [NEST_W-1:0] r_nest;
  logic              r_dir_back;

  // Scan direction flips the sense of brackets: a back scan counts ']' up.
  logic w_nest_up, w_nest_down, w_is_exec, w_pc_last, w_cell_zero;
  assign w_nest_up   = (prog_cmd == c_cmd_open  && !r_dir_back) || (prog_cmd == c_cmd_close && r_dir_back);
  assign w_nest_down = (prog_cmd == c_cmd_close && !r_dir_back) || (prog_cmd == c_cmd_open  && r_dir_back);
  assign w_is_exec   = (prog_cmd != c_cmd_open) && (prog_cmd != c_cmd_close) && (prog_cmd != c_cmd_end);
  assign w_pc_last   = (r_pc == c_pc_max);
  assign w_cell_zero = (cell_value == 8'd0);

`ifdef BF_LOOP_STACK_EN
  localparam int c_sp_w  = $clog2(STACK_DEPTH + 1);
  localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [c_sp_w-1:0] r_sp;
  logic              w_stack_full, w_stack_empty, w_push;
  logic [ADDR_W-1:0] w_top;

  assign w_stack_full  = (r_sp == c_sp_w'(STACK_DEPTH));
  assign w_stack_empty = (r_sp == '0);
  assign w_top         = r_stack[c_idx_w'(r_sp - 1'b1)];
  assign w_push        = (r_state == S_DECODE) && (r_cmd == c_cmd_open) && !w_cell_zero && !w_stack_full;

  always_ff @(posedge clk) begin
    if (w_push) r_stack[c_idx_w'(r_sp)] <= r_pc;
  end
`endif

  assign prog_addr = r_pc;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERROR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_cmd        <= '0;
      r_nest       <= '0;
      r_dir_back   <= 1'b0;
      prog_rd      <= 1'b0;
      exec_valid   <= 1'b0;
      exec_command <= '0;
      halted       <= 1'b0;
      error        <= 1'b0;
`ifdef BF_LOOP_STACK_EN
      r_sp         <= '0;
`endif
    end else begin
      prog_rd <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            r_pc    <= '0;
            r_nest  <= '0;
            halted  <= 1'b0;
            error   <= 1'b0;
            prog_rd <= 1'b1;
            r_state <= S_FETCH;
`ifdef BF_LOOP_STACK_EN
            r_sp    <= '0;
`endif
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_cmd <= prog_cmd;
          if (w_is_exec) begin
            exec_valid   <= 1'b1;
            exec_command <= prog_cmd;
          end
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (r_cmd)
            c_cmd_open: begin
              if (w_cell_zero) begin
                if (w_pc_last) begin
                  error <= 1'b1; r_state <= S_ERROR;
                end else begin
                  r_nest <= NEST_W'(1); r_dir_back <= 1'b0;
                  r_pc <= r_pc + 1'b1; prog_rd <= 1'b1; r_state <= S_SCAN_FETCH;
                end
`ifdef BF_LOOP_STACK_EN
              end else if (w_stack_full) begin
                error <= 1'b1; r_state <= S_ERROR;
`endif
              end else begin
`ifdef BF_LOOP_STACK_EN
                r_sp <= r_sp + 1'b1;
`endif
                if (w_pc_last) begin
                  halted <= 1'b1; r_state <= S_HALT;
                end else begin
                  r_pc <= r_pc + 1'b1; prog_rd <= 1'b1; r_state <= S_FETCH;
                end
              end
            end
            c_cmd_close: begin
`ifdef BF_LOOP_STACK_EN
              if (w_stack_empty) begin
                error <= 1'b1; r_state <= S_ERROR;
              end else if (!w_cell_zero) begin
                r_pc <= w_top + 1'b1; prog_rd <= 1'b1; r_state <= S_FETCH;
              end else begin
                r_sp <= r_sp - 1'b1;
`else
              if (!w_cell_zero) begin
                if (r_pc == '0) begin
                  error <= 1'b1; r_state <= S_ERROR;
                end else begin
                  r_nest <= NEST_W'(1); r_dir_back <= 1'b1;
                  r_pc <= r_pc - 1'b1; prog_rd <= 1'b1; r_state <= S_SCAN_FETCH;
                end
              end else begin
`endif
                if (w_pc_last) begin
                  halted <= 1'b1; r_state <= S_HALT;
                end else begin
                  r_pc <= r_pc + 1'b1; prog_rd <= 1'b1; r_state <= S_FETCH;
                end
              end
            end
            c_cmd_end: begin
              halted <= 1'b1; r_state <= S_HALT;
            end
            default: begin
              if (exec_ready) begin
                exec_valid <= 1'b0;
                if (w_pc_last) begin
                  halted <= 1'b1; r_state <= S_HALT;
                end else begin
                  r_pc <= r_pc + 1'b1; prog_rd <= 1'b1; r_state <= S_FETCH;
                end
              end
            end
          endcase
        end
        S_SCAN_FETCH: r_state <= S_SCAN_WAIT;
        S_SCAN_WAIT: begin
          if (w_nest_up && r_nest == c_nest_max) begin
            error <= 1'b1; r_state <= S_ERROR;
          end else if (w_nest_down && r_nest == NEST_W'(1)) begin
            r_nest <= '0;
            if (w_pc_last) begin
              halted <= 1'b1; r_state <= S_HALT;
            end else begin
              r_pc <= r_pc + 1'b1; prog_rd <= 1'b1; r_state <= S_FETCH;
            end
          end else if ((r_dir_back && r_pc == '0) || (!r_dir_back && w_pc_last)) begin
            error <= 1'b1; r_state <= S_ERROR;
          end else begin
            if (w_nest_up)   r_nest <= r_nest + 1'b1;
            if (w_nest_down) r_nest <= r_nest - 1'b1;
            r_pc    <= r_dir_back ? r_pc - 1'b1 : r_pc + 1'b1;
            prog_rd <= 1'b1;
            r_state <= S_SCAN_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
